rot_dir_calc: RTL

//  Rotation-mode CORDIC direction generator, the inverse of the vectoring-mode angle accumulator.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/angle_quad_reduce.sv | 34 +++
 rtl/rot_dir_calc.sv | 102 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module : cordic_pkg
// Brief  : Shared widths, quadrant codes and atan table for rotation-mode CORDIC.
// Rev    : 1.0
// ============================================================================
package cordic_pkg;

  localparam int DEFAULT_ANGLE_WIDTH   = 16;
  localparam int DEFAULT_CORDIC_STAGES = 16;

  localparam logic [1:0] QUAD_1 = 2'b00;
  localparam logic [1:0] QUAD_2 = 2'b01;
  localparam logic [1:0] QUAD_3 = 2'b11;
  localparam logic [1:0] QUAD_4 = 2'b10;

  // atan(2^-i) in the angle format where 0x8000 weighs pi
  function automatic logic [15:0] atan_lut(input int idx);
    logic [15:0] val;
    case (idx)
      0:       val = 16'h2000;
      1:       val = 16'h12E4;
      2:       val = 16'h09FB;
      3:       val = 16'h0511;
      4:       val = 16'h028B;
      5:       val = 16'h0145;
      6:       val = 16'h00A2;
      7:       val = 16'h0051;
      8:       val = 16'h0028;
      9:       val = 16'h0014;
      10:      val = 16'h000A;
      11:      val = 16'h0005;
      12:      val = 16'h0002;
      13:      val = 16'h0001;
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/angle_quad_reduce.sv
`default_nettype none
// ============================================================================
// Module : angle_quad_reduce
// Brief  : Folds a signed angle into a quadrant code and a [0, pi/2] residual.
// Rev    : 1.0
// ============================================================================
module angle_quad_reduce
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH = DEFAULT_ANGLE_WIDTH
) (
  input  logic [ANGLE_WIDTH-1:0] angle,
  output logic [1:0]             quad,
  output logic [ANGLE_WIDTH-1:0] residual
);

  logic [ANGLE_WIDTH-1:0] neg_angle;

  assign neg_angle = -angle;
  assign quad      = {angle[ANGLE_WIDTH-1], angle[ANGLE_WIDTH-1] ^ angle[ANGLE_WIDTH-2]};

  always_comb begin
    residual = angle;
    case (quad)
      QUAD_1:  residual = angle;
      QUAD_2:  residual = {1'b0, neg_angle[ANGLE_WIDTH-2:0]};
      QUAD_3:  residual = {1'b0, angle[ANGLE_WIDTH-2:0]};
      QUAD_4:  residual = neg_angle;
      default: residual = angle;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rot_dir_calc.sv
`default_nettype none
// ============================================================================
// Module : rot_dir_calc
// Brief  : Rotation-mode CORDIC direction generator (angle -> per-stage dirs + quadrant).
// Rev    : 1.0
// ============================================================================
module rot_dir_calc
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH   = DEFAULT_ANGLE_WIDTH,
  parameter int CORDIC_STAGES = DEFAULT_CORDIC_STAGES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ANGLE_WIDTH-1:0]   angle_in,
  input  logic                     angle_vld_in,
  input  logic [CORDIC_STAGES-1:0] enable_in,
  output logic [CORDIC_STAGES-1:0] micro_rot_dir_out,
  output logic [1:0]               quad_out,
  output logic                     quad_vld_out,
  output logic [ANGLE_WIDTH-1:0]   residual_out,
  output logic                     overrun_err
);

  localparam logic [ANGLE_WIDTH-1:0] ATAN_LAST = atan_lut(CORDIC_STAGES - 1);

  logic [ANGLE_WIDTH-1:0] z         [CORDIC_STAGES];
  logic [1:0]             quad_r    [CORDIC_STAGES];
  logic [CORDIC_STAGES-1:0] stage_vld;

  logic [1:0]             load_quad;
  logic [ANGLE_WIDTH-1:0] load_res;
  logic                   fire_last;

  angle_quad_reduce #(
    .ANGLE_WIDTH(ANGLE_WIDTH)
  ) u_reduce (
    .angle    (angle_in),
    .quad     (load_quad),
    .residual (load_res)
  );

  // A load always wins over the drain of stage 0; overrun only when nothing drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z[0]         <= '0;
      quad_r[0]    <= '0;
      stage_vld[0] <= 1'b0;
      overrun_err  <= 1'b0;
    end else if (angle_vld_in) begin
      z[0]         <= load_res;
      quad_r[0]    <= load_quad;
      stage_vld[0] <= 1'b1;
      if (stage_vld[0] && !enable_in[0]) overrun_err <= 1'b1;
    end else if (enable_in[0]) begin
      stage_vld[0] <= 1'b0;
    end
  end

  for (genvar i = 1; i < CORDIC_STAGES; i++) begin : g_stage
    localparam logic [ANGLE_WIDTH-1:0] ATAN = atan_lut(i - 1);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        z[i]         <= '0;
        quad_r[i]    <= '0;
        stage_vld[i] <= 1'b0;
      end else if (enable_in[i-1]) begin
        z[i]         <= z[i-1][ANGLE_WIDTH-1] ? z[i-1] + ATAN : z[i-1] - ATAN;
        quad_r[i]    <= quad_r[i-1];
        stage_vld[i] <= stage_vld[i-1];
      end
    end
  end

  always_comb begin
    micro_rot_dir_out = '0;
    for (int i = 0; i < CORDIC_STAGES; i++) begin
      micro_rot_dir_out[i] = z[i][ANGLE_WIDTH-1];
    end
  end

  // Gating with stage_vld keeps empty (or reset-dropped) slots from producing a result.
  assign fire_last = enable_in[CORDIC_STAGES-1] & stage_vld[CORDIC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      residual_out <= '0;
      quad_out     <= '0;
      quad_vld_out <= 1'b0;
    end else begin
      quad_vld_out <= fire_last;
      if (fire_last) begin
        residual_out <= z[CORDIC_STAGES-1][ANGLE_WIDTH-1] ? z[CORDIC_STAGES-1] + ATAN_LAST
                                                          : z[CORDIC_STAGES-1] - ATAN_LAST;
        quad_out     <= quad_r[CORDIC_STAGES-1];
      end
    end
  end

endmodule
`default_nettype wire
